// File: rtl/dlx_issue_pkg.sv
// Shared types and the instruction decoder for the DLX issue stage.
`include "common.h.v"

package dlx_issue_pkg;

  localparam int unsigned WORD_W = `WORD_SIZE;
  localparam int unsigned OPC_W  = `OPCODE_WIDTH;
  localparam int unsigned IMM_W  = `IMM_WIDTH;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_e;

  typedef enum logic [1:0] {
    K_NOP,
    K_RTYPE,
    K_ITYPE,
    K_ILLEGAL
  } instr_kind_e;

  typedef struct packed {
    instr_kind_e       kind;
    logic              rtype_op;  // primary opcode is the R-type escape
    logic [OPC_W-1:0]  opcode;    // unified ALU opcode (func or op)
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [IMM_W-1:0]  imm;
  } decoded_t;

  // Field extraction and classification of one instruction word.
  function automatic decoded_t decode(input logic [31:0] instr);
    decoded_t         d;
    logic [OPC_W-1:0] op;
    logic [OPC_W-1:0] fn;
    op         = instr[`F_OP_HI:`F_OP_LO];
    fn         = instr[`F_FUNC_HI:`F_FUNC_LO];
    d.rtype_op = (op == `OP_RTYPE);
    d.rs1      = instr[`F_RS1_HI:`F_RS1_LO];
    d.rs2      = instr[`F_RS2_HI:`F_RS2_LO];
    d.imm      = instr[`F_IMM_HI:`F_IMM_LO];
    d.rd       = instr[`F_RS2_HI:`F_RS2_LO];
    d.opcode   = op;
    d.kind     = K_ILLEGAL;
    if (instr == '0) begin
      d.kind = K_NOP;
    end else if (d.rtype_op) begin
      d.rd     = instr[`F_RD_HI:`F_RD_LO];
      d.opcode = fn;
      case (fn)
        `FN_ADD, `FN_SUB, `FN_AND, `FN_OR, `FN_XOR: d.kind = K_RTYPE;
        default:                                    d.kind = K_ILLEGAL;
      endcase
    end else begin
      case (op)
        `OP_ADDI, `OP_SUBI, `OP_ANDI, `OP_ORI, `OP_XORI: d.kind = K_ITYPE;
        default:                                         d.kind = K_ILLEGAL;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/dlx_issue_if.sv
// ALU operand interface: the registered, handshaked bundle from issue to execute.
`include "common.h.v"

interface dlx_issue_if #(
  parameter int unsigned RAW = 5
);
  logic                     valid;
  logic                     ready;
  logic [`OPCODE_WIDTH-1:0] opcode;
  logic [`WORD_SIZE-1:0]    in1;
  logic                     in2_is_imm;
  logic [`IMM_WIDTH-1:0]    in2_imm;
  logic [`WORD_SIZE-1:0]    in2_readbus;
  logic [RAW-1:0]           rd;

  modport master (
    output valid, opcode, in1, in2_is_imm, in2_imm, in2_readbus, rd,
    input  ready
  );

  modport slave (
    input  valid, opcode, in1, in2_is_imm, in2_imm, in2_readbus, rd,
    output ready
  );
endinterface

// File: rtl/common.h.v
// Shared DLX definitions: datapath widths, opcode / function codes and the
// instruction field bit positions used by the decoder.
`ifndef COMMON_H_V
`define COMMON_H_V

`define WORD_SIZE     32
`define OPCODE_WIDTH  6
`define IMM_WIDTH     16

// Primary opcodes (instr[31:26])
`define OP_RTYPE      6'h00
`define OP_ADDI       6'h08
`define OP_SUBI       6'h0A
`define OP_ANDI       6'h0C
`define OP_ORI        6'h0D
`define OP_XORI       6'h0E

// R-type function codes (instr[5:0])
`define FN_ADD        6'h20
`define FN_SUB        6'h22
`define FN_AND        6'h24
`define FN_OR         6'h25
`define FN_XOR        6'h26

// Instruction field bit positions
`define F_OP_HI       31
`define F_OP_LO       26
`define F_RS1_HI      25
`define F_RS1_LO      21
`define F_RS2_HI      20
`define F_RS2_LO      16
`define F_RD_HI       15
`define F_RD_LO       11
`define F_IMM_HI      15
`define F_IMM_LO      0
`define F_FUNC_HI     5
`define F_FUNC_LO     0

`endif

// File: rtl/dlx_issue_scoreboard.sv
// Per-register pending scoreboard: set on issue, cleared on writeback or
// when a flushed bundle is dropped. r0 is never pending.
`include "common.h.v"

module dlx_scoreboard
   import dlx_issue_pkg::*;
#(
   parameter int unsigned NREG = 32,
   parameter int unsigned RAW  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            set_en,
   input  logic [RAW-1:0]  set_rd,
   input  logic            clr_en,
   input  logic [RAW-1:0]  clr_rd,
   input  logic            drop_en,
   input  logic [RAW-1:0]  drop_rd,
   output logic [NREG-1:0] pending
);

   logic [NREG-1:0] pending_nxt;

   // Clears first, then the set, so a same-cycle set of the register wins.
   always_comb begin
      pending_nxt = pending;
      if (clr_en)
         pending_nxt[clr_rd] = 1'b0;
      if (drop_en)
         pending_nxt[drop_rd] = 1'b0;
      if (set_en)
         pending_nxt[set_rd] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   // Pending vector register.
   always_ff @(posedge clk) begin
      if (rst)
         pending <= '0;
      else
         pending <= pending_nxt;
   end

endmodule

// File: rtl/dlx_issue.sv
// DLX issue stage: decodes R/I-type ALU instructions, reads the register
// file, stalls on RAW hazards via the scoreboard and drives the registered
// operand bundle. Optional macro DLX_ISSUE_BYPASS_EN forwards a same-cycle
// writeback into the source operands and hazard check.
`include "common.h.v"

module dlx_issue
  import dlx_issue_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned RAW  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  output logic [RAW-1:0]        rf_raddr1,
  output logic [RAW-1:0]        rf_raddr2,
  input  logic [`WORD_SIZE-1:0] rf_rdata1,
  input  logic [`WORD_SIZE-1:0] rf_rdata2,
  dlx_issue_if.master           out,
  input  logic                  wb_valid,
  input  logic [RAW-1:0]        wb_rd,
  input  logic [`WORD_SIZE-1:0] wb_data,
  input  logic                  flush,
  output logic                  illegal
);

  decoded_t              dec;
  out_state_e            state;
  logic [NREG-1:0]       pending;
  logic                  src1_busy;
  logic                  src2_busy;
  logic [`WORD_SIZE-1:0] src1_val;
  logic [`WORD_SIZE-1:0] src2_val;
  logic                  hazard;
  logic                  accept;
  logic                  issue;
  logic                  reject;

  assign dec       = decode(in_instr);
  assign rf_raddr1 = dec.rs1;
  assign rf_raddr2 = dec.rs2;

`ifdef DLX_ISSUE_BYPASS_EN
  logic byp1;
  logic byp2;

  // A writeback landing this cycle satisfies the matching source directly.
  assign byp1      = wb_valid && (wb_rd == dec.rs1) && (dec.rs1 != '0);
  assign byp2      = wb_valid && (wb_rd == dec.rs2) && (dec.rs2 != '0);
  assign src1_busy = pending[dec.rs1] && !byp1;
  assign src2_busy = pending[dec.rs2] && !byp2;
  assign src1_val  = byp1 ? wb_data : rf_rdata1;
  assign src2_val  = byp2 ? wb_data : rf_rdata2;
`else
  logic unused_wb_data;

  assign unused_wb_data = ^wb_data;
  assign src1_busy      = pending[dec.rs1];
  assign src2_busy      = pending[dec.rs2];
  assign src1_val       = rf_rdata1;
  assign src2_val       = rf_rdata2;
`endif

  assign hazard   = ((dec.rs1 != '0) && src1_busy) ||
                    (dec.rtype_op && (dec.rs2 != '0) && src2_busy);
  assign in_ready = !rst && !flush && !hazard &&
                    ((state == OUT_EMPTY) || out.ready);
  assign accept   = in_valid && in_ready;
  assign issue    = accept && ((dec.kind == K_RTYPE) || (dec.kind == K_ITYPE));
  assign reject   = accept && (dec.kind == K_ILLEGAL);

  assign out.valid = (state == OUT_FULL);

  dlx_scoreboard #(
    .NREG (NREG),
    .RAW  (RAW)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (issue && (dec.rd != '0)),
    .set_rd  (dec.rd),
    .clr_en  (wb_valid),
    .clr_rd  (wb_rd),
    .drop_en (flush && (state == OUT_FULL)),
    .drop_rd (out.rd),
    .pending (pending)
  );

  // Output register FSM: flush drops the entry, an issue (re)fills it,
  // otherwise a consumed entry empties it; fields hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= OUT_EMPTY;
      out.opcode      <= '0;
      out.in1         <= '0;
      out.in2_is_imm  <= 1'b0;
      out.in2_imm     <= '0;
      out.in2_readbus <= '0;
      out.rd          <= '0;
      illegal         <= 1'b0;
    end else begin
      illegal <= reject;
      if (flush) begin
        state <= OUT_EMPTY;
      end else if (issue) begin
        state           <= OUT_FULL;
        out.opcode      <= dec.opcode;
        out.in1         <= src1_val;
        out.in2_is_imm  <= (dec.kind == K_ITYPE);
        out.in2_imm     <= (dec.kind == K_ITYPE) ? dec.imm : '0;
        out.in2_readbus <= (dec.kind == K_RTYPE) ? src2_val : '0;
        out.rd          <= dec.rd;
      end else if (out.ready) begin
        state <= OUT_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_dlx_issue.sv
// Self-checking bench for dlx_issue: directed scenarios plus a randomized
// run, all checked against a behavioural model of the issue rules.
module tb_dlx_issue;
   import dlx_issue_pkg::*;

`ifdef DLX_ISSUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [4:0]  rf_raddr1;
   logic [4:0]  rf_raddr2;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic        out_ready;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush;
   logic        illegal;

   logic [31:0] rf [32];

   dlx_issue_if #(.RAW(5)) out_if ();

   dlx_issue #(
      .NREG (32),
      .RAW  (5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .rf_raddr1 (rf_raddr1),
      .rf_raddr2 (rf_raddr2),
      .rf_rdata1 (rf_rdata1),
      .rf_rdata2 (rf_rdata2),
      .out       (out_if),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .flush     (flush),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   assign rf_rdata1    = rf[rf_raddr1];
   assign rf_rdata2    = rf[rf_raddr2];
   assign out_if.ready = out_ready;

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   bit          m_pend [32];
   bit          m_full;
   logic [5:0]  m_opc;
   logic [31:0] m_in1;
   bit          m_isimm;
   logic [15:0] m_imm;
   logic [31:0] m_rb;
   logic [4:0]  m_rd;
   bit          m_ill;
   bit          m_inrdy;
   bit          s_inrdy;

   function automatic logic [31:0] mk_r(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] a, input logic [4:0] b);
      return {6'h00, a, b, rd, 5'h00, fn};
   endfunction

   function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] a, input logic [15:0] imm);
      return {op, a, rd, imm};
   endfunction

   function automatic bit busy(input logic [4:0] r);
      return m_pend[r] && !(BYP && wb_valid && (wb_rd == r));
   endfunction

   function automatic logic [31:0] srcval(input logic [4:0] r);
      if (BYP && wb_valid && (wb_rd == r) && (r != 5'd0))
         return wb_data;
      return rf[r];
   endfunction

   // One clock: sample in_ready mid-cycle, predict it, advance the model at
   // the edge, and return 1 time unit after the edge.
   task automatic tick();
      logic [5:0] op, fn;
      logic [4:0] a, b, d;
      bit         rtype, nop, legal, hz, acc, iss;
      #2;
      op    = in_instr[31:26];
      fn    = in_instr[5:0];
      a     = in_instr[25:21];
      b     = in_instr[20:16];
      rtype = (op == 6'h00);
      nop   = (in_instr == 32'd0);
      legal = rtype ? (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26})
                    : (op inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E});
      d     = rtype ? in_instr[15:11] : b;
      hz    = ((a != 5'd0) && busy(a)) || (rtype && (b != 5'd0) && busy(b));
      m_inrdy = !rst && !flush && !hz && (!m_full || out_ready);
      s_inrdy = in_ready;
      acc   = in_valid && m_inrdy;
      iss   = acc && legal;
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
         m_full = 1'b0; m_opc = '0; m_in1 = '0; m_isimm = 1'b0;
         m_imm = '0; m_rb = '0; m_rd = '0; m_ill = 1'b0;
      end else begin
         m_ill = acc && !legal && !nop;
         if (wb_valid) m_pend[wb_rd] = 1'b0;
         if (flush && m_full) m_pend[m_rd] = 1'b0;
         if (iss && (d != 5'd0)) m_pend[d] = 1'b1;
         if (flush) begin
            m_full = 1'b0;
         end else if (iss) begin
            m_full  = 1'b1;
            m_opc   = rtype ? fn : op;
            m_in1   = srcval(a);
            m_isimm = !rtype;
            m_imm   = rtype ? 16'h0000 : in_instr[15:0];
            m_rb    = rtype ? srcval(b) : 32'd0;
            m_rd    = d;
         end else if (out_ready) begin
            m_full = 1'b0;
         end
      end
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0; in_instr = '0; flush = 1'b0;
      wb_valid = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      total++; if (s_inrdy !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", s_inrdy); end
      total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_if.valid); end
      total++;
      if ({out_if.opcode, out_if.in1, out_if.in2_is_imm, out_if.in2_imm, out_if.in2_readbus, out_if.rd} !== '0) begin
         bad++; $display("FAIL rst_fields: got %h %h %b %h %h %h want all 0", out_if.opcode, out_if.in1,
                         out_if.in2_is_imm, out_if.in2_imm, out_if.in2_readbus, out_if.rd);
      end
      total++; if (illegal !== 1'b0) begin bad++; $display("FAIL rst_illegal: got %b want 0", illegal); end
      rst = 1'b0;
      tick();
      total++; if (s_inrdy !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got %b want 1", s_inrdy); end
   endtask

   task automatic test_addi();
      in_valid = 1'b1;
      in_instr = mk_i(6'h08, 5'd3, 5'd1, 16'h8000);
      tick();
      in_valid = 1'b0;
      total++; if (s_inrdy !== 1'b1) begin bad++; $display("FAIL addi_in_ready: got %b want 1", s_inrdy); end
      total++; if (out_if.valid !== 1'b1) begin bad++; $display("FAIL addi_valid: got %b want 1", out_if.valid); end
      total++; if (out_if.opcode !== 6'h08) begin bad++; $display("FAIL addi_opcode: got %h want 08", out_if.opcode); end
      total++; if (out_if.in1 !== 32'd5) begin bad++; $display("FAIL addi_in1: got %h want 5", out_if.in1); end
      total++; if (out_if.in2_is_imm !== 1'b1) begin bad++; $display("FAIL addi_is_imm: got %b want 1", out_if.in2_is_imm); end
      total++; if (out_if.in2_imm !== 16'h8000) begin bad++; $display("FAIL addi_imm: got %h want 8000", out_if.in2_imm); end
      total++; if (out_if.in2_readbus !== 32'd0) begin bad++; $display("FAIL addi_readbus: got %h want 0", out_if.in2_readbus); end
      total++; if (out_if.rd !== 5'd3) begin bad++; $display("FAIL addi_rd: got %0d want 3", out_if.rd); end
   endtask

   task automatic test_raw_stall();
      in_valid  = 1'b1;
      in_instr  = mk_r(6'h20, 5'd4, 5'd3, 5'd2);
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (s_inrdy !== 1'b0) begin bad++; $display("FAIL raw_stall_%0d: got %b want 0", i, s_inrdy); end
      end
      wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hABCD_0123;
      tick();
`ifdef DLX_ISSUE_BYPASS_EN
      total++; if (s_inrdy !== 1'b1) begin bad++; $display("FAIL raw_wb_cycle: got %b want 1", s_inrdy); end
      total++; if (out_if.in1 !== 32'hABCD_0123) begin bad++; $display("FAIL raw_bypass_in1: got %h want abcd0123", out_if.in1); end
      wb_valid = 1'b0;
      in_valid = 1'b0;
`else
      total++; if (s_inrdy !== 1'b0) begin bad++; $display("FAIL raw_wb_cycle: got %b want 0", s_inrdy); end
      wb_valid = 1'b0;
      tick();
      in_valid = 1'b0;
      total++; if (s_inrdy !== 1'b1) begin bad++; $display("FAIL raw_after_wb: got %b want 1", s_inrdy); end
      total++; if (out_if.in1 !== rf[3]) begin bad++; $display("FAIL raw_in1: got %h want %h", out_if.in1, rf[3]); end
`endif
      total++; if (out_if.in2_readbus !== rf[2]) begin bad++; $display("FAIL raw_readbus: got %h want %h", out_if.in2_readbus, rf[2]); end
      total++; if (out_if.opcode !== 6'h20 || out_if.rd !== 5'd4) begin
         bad++; $display("FAIL raw_op_rd: got %h/%0d want 20/4", out_if.opcode, out_if.rd);
      end
   endtask

   task automatic test_back_to_back();
      idle();
      tick();
      in_valid  = 1'b1;
      in_instr  = mk_r(6'h25, 5'd5, 5'd1, 5'd2);
      out_ready = 1'b0;
      tick();
      total++; if (s_inrdy !== 1'b1) begin bad++; $display("FAIL bp_first_accept: got %b want 1", s_inrdy); end
      in_instr = mk_i(6'h0D, 5'd6, 5'd1, 16'h1234);
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (s_inrdy !== 1'b0) begin bad++; $display("FAIL bp_hold_ready_%0d: got %b want 0", i, s_inrdy); end
         total++;
         if (out_if.valid !== 1'b1 || out_if.opcode !== 6'h25 || out_if.in1 !== 32'd5 ||
             out_if.in2_readbus !== 32'h11 || out_if.rd !== 5'd5 || out_if.in2_is_imm !== 1'b0) begin
            bad++; $display("FAIL bp_hold_%0d: got v=%b op=%h in1=%h rb=%h rd=%0d want v=1 op=25 in1=5 rb=11 rd=5",
                            i, out_if.valid, out_if.opcode, out_if.in1, out_if.in2_readbus, out_if.rd);
         end
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      total++; if (s_inrdy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got %b want 1", s_inrdy); end
      total++;
      if (out_if.valid !== 1'b1 || out_if.opcode !== 6'h0D || out_if.in2_imm !== 16'h1234 ||
          out_if.in2_is_imm !== 1'b1 || out_if.rd !== 5'd6) begin
         bad++; $display("FAIL b2b_bundle: got v=%b op=%h imm=%h rd=%0d want v=1 op=0d imm=1234 rd=6",
                         out_if.valid, out_if.opcode, out_if.in2_imm, out_if.rd);
      end
      tick();
      total++; if (out_if.valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", out_if.valid); end
   endtask

   task automatic test_illegal_nop();
      idle();
      in_valid = 1'b1;
      in_instr = 32'hFC00_0000;
      tick();
      total++; if (illegal !== 1'b1 || out_if.valid !== 1'b0) begin
         bad++; $display("FAIL ill_op: got ill=%b v=%b want ill=1 v=0", illegal, out_if.valid);
      end
      in_instr = 32'd0;
      tick();
      total++; if (illegal !== 1'b0 || out_if.valid !== 1'b0 || s_inrdy !== 1'b1) begin
         bad++; $display("FAIL nop: got ill=%b v=%b rdy=%b want ill=0 v=0 rdy=1", illegal, out_if.valid, s_inrdy);
      end
      in_instr = 32'hFC09_0000;
      tick();
      total++; if (illegal !== 1'b1) begin bad++; $display("FAIL ill_op_rt9: got %b want 1", illegal); end
      in_instr = mk_r(6'h21, 5'd10, 5'd1, 5'd2);
      tick();
      total++; if (illegal !== 1'b1 || out_if.valid !== 1'b0) begin
         bad++; $display("FAIL ill_func: got ill=%b v=%b want ill=1 v=0", illegal, out_if.valid);
      end
      in_instr = mk_r(6'h20, 5'd11, 5'd9, 5'd10);
      tick();
      in_valid = 1'b0;
      total++; if (s_inrdy !== 1'b1 || illegal !== 1'b0 || out_if.valid !== 1'b1) begin
         bad++; $display("FAIL ill_no_pending: got rdy=%b ill=%b v=%b want rdy=1 ill=0 v=1", s_inrdy, illegal, out_if.valid);
      end
   endtask

   task automatic test_flush();
      idle();
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = mk_r(6'h26, 5'd7, 5'd1, 5'd2);
      tick();
      total++; if (out_if.valid !== 1'b1 || out_if.rd !== 5'd7) begin
         bad++; $display("FAIL flush_fill: got v=%b rd=%0d want v=1 rd=7", out_if.valid, out_if.rd);
      end
      in_instr = mk_i(6'h08, 5'd8, 5'd7, 16'h0001);
      flush    = 1'b1;
      tick();
      total++; if (s_inrdy !== 1'b0 || out_if.valid !== 1'b0) begin
         bad++; $display("FAIL flush_drop: got rdy=%b v=%b want rdy=0 v=0", s_inrdy, out_if.valid);
      end
      flush = 1'b0;
      tick();
      in_valid = 1'b0;
      total++; if (s_inrdy !== 1'b1 || out_if.valid !== 1'b1 || out_if.rd !== 5'd8) begin
         bad++; $display("FAIL flush_r7_free: got rdy=%b v=%b rd=%0d want rdy=1 v=1 rd=8", s_inrdy, out_if.valid, out_if.rd);
      end
   endtask

   task automatic test_r0();
      idle();
      tick();
      in_valid = 1'b1;
      in_instr = mk_r(6'h20, 5'd0, 5'd0, 5'd0);
      tick();
      total++; if (s_inrdy !== 1'b1 || out_if.valid !== 1'b1 || out_if.rd !== 5'd0) begin
         bad++; $display("FAIL r0_add: got rdy=%b v=%b rd=%0d want rdy=1 v=1 rd=0", s_inrdy, out_if.valid, out_if.rd);
      end
      in_instr = mk_i(6'h08, 5'd9, 5'd0, 16'h0005);
      tick();
      total++; if (s_inrdy !== 1'b1 || out_if.in1 !== 32'd0) begin
         bad++; $display("FAIL r0_src: got rdy=%b in1=%h want rdy=1 in1=0", s_inrdy, out_if.in1);
      end
      in_instr = mk_r(6'h22, 5'd12, 5'd0, 5'd0);
      tick();
      in_valid = 1'b0;
      total++; if (s_inrdy !== 1'b1) begin bad++; $display("FAIL r0_after_r0_dest: got %b want 1", s_inrdy); end
   endtask

   task automatic test_random();
      logic [5:0] fns [5];
      logic [5:0] ops [5];
      int unsigned k;
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};
      ops = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E};
      for (int n = 0; n < 3000; n++) begin
         rst      = ($urandom_range(0, 499) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         k        = $urandom_range(0, 9);
         if (k == 0)
            in_instr = 32'd0;
         else if (k == 1)
            in_instr = $urandom;
         else if (k < 6)
            in_instr = mk_r(fns[$urandom_range(0, 4)], 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         else
            in_instr = mk_i(ops[$urandom_range(0, 4)], 5'($urandom_range(0, 7)),
                            5'($urandom_range(0, 7)), 16'($urandom));
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         wb_valid  = ($urandom_range(0, 2) == 0);
         wb_rd     = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         wb_data   = $urandom;
         tick();
         total++; if (s_inrdy !== m_inrdy) begin bad++; $display("FAIL rnd_in_ready@%0d: got %b want %b", n, s_inrdy, m_inrdy); end
         total++; if (out_if.valid !== m_full) begin bad++; $display("FAIL rnd_valid@%0d: got %b want %b", n, out_if.valid, m_full); end
         total++; if (illegal !== m_ill) begin bad++; $display("FAIL rnd_illegal@%0d: got %b want %b", n, illegal, m_ill); end
         if (m_full) begin
            total++;
            if (out_if.opcode !== m_opc || out_if.in1 !== m_in1 || out_if.in2_is_imm !== m_isimm ||
                out_if.in2_imm !== m_imm || out_if.in2_readbus !== m_rb || out_if.rd !== m_rd) begin
               bad++; $display("FAIL rnd_bundle@%0d: got %h %h %b %h %h %0d want %h %h %b %h %h %0d", n,
                               out_if.opcode, out_if.in1, out_if.in2_is_imm, out_if.in2_imm, out_if.in2_readbus, out_if.rd,
                               m_opc, m_in1, m_isimm, m_imm, m_rb, m_rd);
            end
         end
      end
      rst = 1'b0;
      idle();
   endtask

   initial begin
      rf[0] = 32'd0;
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      rf[1] = 32'd5;
      rf[2] = 32'h0000_0011;
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      m_full = 1'b0;
      test_reset();
      test_addi();
      test_raw_stall();
      test_back_to_back();
      test_illegal_nop();
      test_flush();
      test_r0();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dlx_issue.md
Name: dlx_issue

Overview:
- Issue stage of the DLX integer pipeline; the producer side of the ALU operand interface.
- Accepts fetched 32-bit instruction words and decodes R/I-type ALU instructions.
- Reads the register file, checks a per-register pending scoreboard for RAW hazards, and drives a registered, handshaked operand bundle: opcode, in1, in2_is_imm, in2_imm, in2_readbus, plus destination rd.
- Writeback returns completed destinations to clear the scoreboard.

Parameters:
- NREG, 32, number of architectural registers; r0 is hard-wired zero.
- RAW, 5, register address width; NREG == 2**RAW.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  fetch presents in_instr.
- in_ready  out  1  instruction consumed this cycle.
- in_instr  in  32  DLX instruction word.
- rf_raddr1  out  RAW  rs1 address, combinational from in_instr.
- rf_raddr2  out  RAW  rs2 address, combinational from in_instr.
- rf_rdata1  in  `word_size  async read data for rf_raddr1.
- rf_rdata2  in  `word_size  async read data for rf_raddr2.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  ALU/execute accepts the bundle.
- out_opcode  out  `opcode_width  unified ALU opcode.
- out_in1  out  `word_size  rs1 value.
- out_in2_is_imm  out  1  selects immediate.
- out_in2_imm  out  `imm_width  raw immediate.
- out_in2_readbus  out  `word_size  rs2 value; 0 for I-type.
- out_rd  out  RAW  destination register.
- wb_valid  in  1  writeback completes.
- wb_rd  in  RAW  register being written back.
- wb_data  in  `word_size  writeback value; used only with the bypass option.
- flush  in  1  squash the output register.
- illegal  out  1  one-cycle pulse on an unsupported instruction.

Behaviour:
- Decode fields:
  - op = instr[31:26], rs1 = [25:21].
  - R-type (op == 0): rs2 = [20:16], rd = [15:11], func = [5:0], out_opcode = func.
  - I-type: rd = [20:16], imm = [15:0], out_opcode = op, in2_is_imm = 1.
- Supported opcodes: ADD, SUB, AND, OR, XOR and their I forms, encoded via `common.h.v`.
- instr == 0 is a NOP: consumed, not issued, no illegal pulse.
- Any other encoding: consumed, not issued, illegal = 1 for one cycle.
- Hazard:
  - hazard = (rs1 != 0 && pending[rs1]) || (R-type && rs2 != 0 && pending[rs2]).
  - Sources in r0 never stall.
- in_ready = !rst && !flush && !hazard && (!out_valid || out_ready). in_ready may depend on in_instr.
- Output register states:
  - EMPTY → FULL on an issuing accept.
  - FULL stays FULL if out_ready and a new issue occurs in the same cycle.
  - FULL → EMPTY on out_ready without an issue, or on flush.
  - Outputs are held stable while out_valid && !out_ready.
- Latency: one cycle from accept to out_valid.
- Scoreboard:
  - Set pending[rd] on issue when rd != 0.
  - Clear pending[wb_rd] on wb_valid.
  - Clear and set of the same register in one cycle: set wins.
  - A clear is visible to hazard detection the next cycle; no same-cycle bypass without the option.
  - pending[0] is always 0.
- flush:
  - Drops a FULL entry, which is not seen by execute.
  - Clears pending[out_rd] for the dropped entry unless wb_valid sets nothing else.
  - in_ready = 0 that cycle.
- Reset:
  - out_valid = 0, all out_* fields = 0, illegal = 0, pending = 0.
  - Any held bundle is discarded.

Optional Feature:
- Macro DLX_ISSUE_BYPASS_EN.
- Defined:
  - A source matching wb_rd with wb_valid is treated as not pending that cycle.
  - The operand is taken from wb_data instead of rf_rdata*.
  - Removes one stall cycle.
- Undefined: stall behaviour as specified above; wb_data is ignored.

Decomposition:
- `common.h.v` holds `word_size, `opcode_width, `imm_width, and the opcode codes.
- Add `OP_RTYPE (6'h00) and the field bit positions there.
- The scoreboard (set/clear/read of the pending vector) is a natural sub-module: dlx_scoreboard.

Test Plan:
- After rst, ADDI r3,r1,0x8000 with rf_rdata1 = 5 → next cycle out_valid = 1, out_opcode = ADDI, out_in1 = 5, out_in2_is_imm = 1, out_in2_imm = 16'h8000, out_rd = 3.
- ADD r4,r3,r2 issued immediately after the ADDI to r3 → in_ready = 0 until the cycle after wb_valid with wb_rd = 3; with DLX_ISSUE_BYPASS_EN, issues in the wb cycle with out_in1 = wb_data.
- out_ready held 0 for 3 cycles with the bundle FULL → all out_* stable, in_ready = 0; out_ready = 1 with a new instr pending → back-to-back issue, no bubble.
- instr = 32'hFC000000 (unsupported op) → illegal pulses 1 cycle, out_valid stays 0, no pending bit set; instr = 0 → no illegal, no issue.
- Issue XOR to r7, then flush while FULL → out_valid = 0 next cycle and pending[7] cleared; a following read of r7 does not stall.
- ADD r0,r0,r0 and sources r0 under any scoreboard state → no stall, pending[0] never set.
